// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl -- control unit for an HH:MM:SS clock with a button-driven
// time-setting mode.
//
// A prescaler divides clk down to an internal one-second tick. Two raw
// buttons (mode, increment) are synchronised, debounced and edge-detected.
// A four-state controller then issues one-cycle count-enable / clear strobes
// to an external seconds/minutes/hours datapath and drives a blink phase for
// the field being set.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   reset     in   asynchronous active-low reset
//   en        in   run enable (only meaningful in RUN)
//   mode_btn  in   raw mode button, active-high, asynchronous
//   inc_btn   in   raw increment button, active-high, asynchronous
//   sec_tc    in   datapath flag: seconds counter at 59
//   min_tc    in   datapath flag: minutes counter at 59
//   sec_ce    out  seconds count-enable strobe
//   min_ce    out  minutes count-enable strobe
//   hour_ce   out  hours count-enable strobe
//   sec_clr   out  seconds synchronous-clear strobe
//   mode      out  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink     out  blink phase for the field being set
// ---------------------------------------------------------------------------

// Button conditioner: 2-flop synchroniser, stability debouncer and a
// single-cycle pulse on each accepted 0->1 transition.
module time_set_deb #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

    logic [1:0]    sync_r;
    logic          acc_r;
    logic [DW-1:0] cnt_r;
    logic          pulse_r;

    // Synchronise, then count consecutive samples that disagree with the
    // accepted level; a sample agreeing with it restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= 2'b00;
            acc_r   <= 1'b0;
            cnt_r   <= {DW{1'b0}};
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], btn};
            pulse_r <= 1'b0;
            if (sync_r[1] == acc_r) begin
                cnt_r <= {DW{1'b0}};
            end else if (cnt_r == DEB_MAX) begin
                acc_r   <= sync_r[1];
                cnt_r   <= {DW{1'b0}};
                pulse_r <= sync_r[1];
            end else begin
                cnt_r <= cnt_r + DW'(1);
            end
        end
    end

    assign pulse = pulse_r;
endmodule

module time_set_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEB_CYC  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       sec_tc,
    input  logic       min_tc,
    output logic       sec_ce,
    output logic       min_ce,
    output logic       hour_ce,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    state_t        state_r, state_nx_s;
    logic [PW-1:0] pre_r, pre_nx_s;
    logic          blink_r, blink_nx_s;
    logic          sec_ce_r, min_ce_r, hour_ce_r, sec_clr_r;
    logic          sec_ce_nx_s, min_ce_nx_s, hour_ce_nx_s, sec_clr_nx_s;
    logic          mode_p_s, inc_p_s, inc_act_s, adv_s, tick_s;

    time_set_deb #(.DEB_CYC(DEB_CYC)) u_deb_mode (
        .clk(clk), .reset(reset), .btn(mode_btn), .pulse(mode_p_s)
    );
    time_set_deb #(.DEB_CYC(DEB_CYC)) u_deb_inc (
        .clk(clk), .reset(reset), .btn(inc_btn), .pulse(inc_p_s)
    );

    // Prescaler only freezes in RUN with en low; it keeps running while
    // setting so the blink phase stays alive.
    assign adv_s     = !((state_r == ST_RUN) && !en);
    assign tick_s    = adv_s && (pre_r == PRE_MAX);
    // A mode press swallows a simultaneous increment press.
    assign inc_act_s = inc_p_s && !mode_p_s;

    // Next-state logic: mode press walks RUN->HOUR->MIN->SEC->RUN.
    always_comb begin
        state_nx_s = state_r;
        if (mode_p_s) begin
            case (state_r)
                ST_RUN:      state_nx_s = ST_SET_HOUR;
                ST_SET_HOUR: state_nx_s = ST_SET_MIN;
                ST_SET_MIN:  state_nx_s = ST_SET_SEC;
                ST_SET_SEC:  state_nx_s = ST_RUN;
                default:     state_nx_s = ST_RUN;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Prescaler, blink and strobe next values.
    always_comb begin
        pre_nx_s     = pre_r;
        blink_nx_s   = blink_r;
        sec_ce_nx_s  = 1'b0;
        min_ce_nx_s  = 1'b0;
        hour_ce_nx_s = 1'b0;
        sec_clr_nx_s = 1'b0;

        // Zeroing the seconds (or leaving SET_SEC) restarts the second so
        // the next tick is a full period away.
        if ((state_r == ST_SET_SEC) && (mode_p_s || inc_p_s)) begin
            pre_nx_s = {PW{1'b0}};
        end else if (adv_s) begin
            pre_nx_s = tick_s ? {PW{1'b0}} : (pre_r + PW'(1));
        end else begin
            pre_nx_s = pre_r;
        end

        if (mode_p_s) begin
            blink_nx_s = (state_nx_s != ST_RUN);
        end else if (state_r == ST_RUN) begin
            blink_nx_s = 1'b0;
        end else if (tick_s) begin
            blink_nx_s = ~blink_r;
        end else begin
            blink_nx_s = blink_r;
        end

        case (state_r)
            ST_RUN: begin
                sec_ce_nx_s  = en && tick_s;
                min_ce_nx_s  = en && tick_s && sec_tc;
                hour_ce_nx_s = en && tick_s && sec_tc && min_tc;
            end
            ST_SET_HOUR: hour_ce_nx_s = inc_act_s;
            ST_SET_MIN:  min_ce_nx_s  = inc_act_s;
            ST_SET_SEC:  sec_clr_nx_s = inc_act_s;
            default: begin
                sec_ce_nx_s  = 1'b0;
                min_ce_nx_s  = 1'b0;
                hour_ce_nx_s = 1'b0;
                sec_clr_nx_s = 1'b0;
            end
        endcase
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_RUN;
            pre_r     <= {PW{1'b0}};
            blink_r   <= 1'b0;
            sec_ce_r  <= 1'b0;
            min_ce_r  <= 1'b0;
            hour_ce_r <= 1'b0;
            sec_clr_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pre_r     <= pre_nx_s;
            blink_r   <= blink_nx_s;
            sec_ce_r  <= sec_ce_nx_s;
            min_ce_r  <= min_ce_nx_s;
            hour_ce_r <= hour_ce_nx_s;
            sec_clr_r <= sec_clr_nx_s;
        end
    end

    assign sec_ce  = sec_ce_r;
    assign min_ce  = min_ce_r;
    assign hour_ce = hour_ce_r;
    assign sec_clr = sec_clr_r;
    assign mode    = state_r;
    assign blink   = blink_r;
endmodule
